// File: rtl/scroll_ctrl.sv
// Control side of the scroll block: debounces the move button, runs the game FSM,
// turns scrolled distance into a lane score and ramps speed at score milestones.
module scroll_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MOVE_STEP       = 8,
  parameter int LANE_H          = 40,
  parameter int SPEED_EVERY     = 10,
  parameter int SPEED_STEP      = 4,
  parameter int SPEED_MAX       = 200
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        game_rst,
  input  logic        btn_move,
  input  logic        collision,
  input  logic [10:0] pos_in,
  output logic        halt,
  output logic [7:0]  move_amt,
  output logic [7:0]  speed_change,
  output logic [15:0] score,
  output logic        game_over
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MS_W = $clog2(SPEED_EVERY + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MS_W-1:0] MS_LAST  = MS_W'(SPEED_EVERY - 1);
  localparam logic [11:0]     LANE     = 12'(LANE_H);
  localparam logic [8:0]      SPD_STEP = 9'(SPEED_STEP);
  localparam logic [8:0]      SPD_MAX  = 9'(SPEED_MAX);
  localparam logic [7:0]      STEP     = 8'(MOVE_STEP);

  typedef enum logic [1:0] {IDLE, MOVE, STOP, DEAD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              btn_s1;
  logic              btn_s2;
  logic              btn_db;
  logic              btn_db_q;
  logic              btn_rise;
  logic [DB_W-1:0]   db_cnt;
  logic [10:0]       pos_prev;
  logic [10:0]       delta;
  logic [11:0]       acc;
  logic [11:0]       gain;
  logic [11:0]       lane_sum;
  logic              lane_hit;
  logic              score_inc;
  logic [MS_W-1:0]   ms_cnt;
  logic [8:0]        spd_sum;
  logic [7:0]        spd_next;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn_move;
      btn_s2 <= btn_s1;
    end
  end

  // btn_db is deliberately kept across game_rst so a held button must be re-pressed to start
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (game_rst || btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign btn_rise = btn_db & ~btn_db_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (btn_rise) state_nxt = MOVE;
      MOVE: begin
        if (collision)    state_nxt = DEAD;
        else if (!btn_db) state_nxt = STOP;
      end
      STOP: begin
        if (collision)    state_nxt = DEAD;
        else if (btn_db)  state_nxt = MOVE;
      end
      default: state_nxt = DEAD;
    endcase
    if (game_rst) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= IDLE;
      halt      <= 1'b1;
      move_amt  <= 8'd0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      halt      <= (state_nxt != MOVE);
      move_amt  <= (state_nxt == MOVE) ? STEP : 8'd0;
      game_over <= (state_nxt == DEAD);
    end
  end

  // Unsigned 11-bit subtraction makes a position wrap look like ordinary forward travel
  assign delta     = pos_in - pos_prev;
  assign gain      = (state == MOVE) ? {1'b0, delta} : 12'd0;
  assign lane_sum  = acc + gain;
  assign lane_hit  = (lane_sum >= LANE);
  assign score_inc = lane_hit && (score != 16'hFFFF);
  assign spd_sum   = {1'b0, speed_change} + SPD_STEP;
  assign spd_next  = (spd_sum > SPD_MAX) ? SPD_MAX[7:0] : spd_sum[7:0];

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pos_prev     <= 11'd0;
      acc          <= 12'd0;
      score        <= 16'd0;
      ms_cnt       <= '0;
      speed_change <= 8'd0;
    end else if (game_rst) begin
      pos_prev     <= pos_in;
      acc          <= 12'd0;
      score        <= 16'd0;
      ms_cnt       <= '0;
      speed_change <= 8'd0;
    end else begin
      pos_prev <= pos_in;
      acc      <= lane_hit ? (lane_sum - LANE) : lane_sum;
      if (score_inc) begin
        score <= score + 16'd1;
        if (ms_cnt == MS_LAST) begin
          ms_cnt       <= '0;
          speed_change <= spd_next;
        end else begin
          ms_cnt <= ms_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Scoreboard bench for scroll_ctrl: short debounce, low speed ceiling so saturation is reachable.
module tb_scroll_ctrl;

  localparam int DB          = 4;
  localparam int LANE_H      = 40;
  localparam int SPEED_EVERY = 10;
  localparam int SPEED_STEP  = 4;
  localparam int SPEED_MAX   = 12;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        game_rst;
  logic        btn_move;
  logic        collision;
  logic [10:0] pos_in;
  logic        halt;
  logic [7:0]  move_amt;
  logic [7:0]  speed_change;
  logic [15:0] score;
  logic        game_over;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] score;
    logic [7:0]  speed;
  } exp_t;

  exp_t        sb_q[$];
  int          m_acc;
  int          m_score;
  int          m_ms;
  int          m_speed;
  logic [10:0] m_prev;
  bit          m_moving;

  scroll_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .MOVE_STEP(8),
    .LANE_H(LANE_H),
    .SPEED_EVERY(SPEED_EVERY),
    .SPEED_STEP(SPEED_STEP),
    .SPEED_MAX(SPEED_MAX)
  ) dut (
    .clk(clk),
    .sys_rst(sys_rst),
    .game_rst(game_rst),
    .btn_move(btn_move),
    .collision(collision),
    .pos_in(pos_in),
    .halt(halt),
    .move_amt(move_amt),
    .speed_change(speed_change),
    .score(score),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    m_acc    = 0;
    m_score  = 0;
    m_ms     = 0;
    m_speed  = 0;
    m_prev   = pos_in;
    m_moving = 1'b0;
  endtask

  // Drives a new position and queues the score/speed the next edge should produce
  task automatic drive_pos(input logic [10:0] new_pos);
    exp_t        e;
    logic [10:0] d;
    int          sum;
    d      = new_pos - m_prev;
    m_prev = new_pos;
    sum    = m_acc + (m_moving ? int'(d) : 0);
    if (sum >= LANE_H) begin
      m_acc = sum - LANE_H;
      if (m_score < 65535) begin
        m_score++;
        m_ms++;
        if (m_ms == SPEED_EVERY) begin
          m_ms    = 0;
          m_speed = (m_speed + SPEED_STEP > SPEED_MAX) ? SPEED_MAX : m_speed + SPEED_STEP;
        end
      end
    end else begin
      m_acc = sum;
    end
    e.score = 16'(m_score);
    e.speed = 8'(m_speed);
    sb_q.push_back(e);
    pos_in = new_pos;
  endtask

  task automatic test_reset();
    sys_rst   = 1'b0;
    game_rst  = 1'b0;
    collision = 1'b0;
    pos_in    = 11'd0;
    btn_move  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn_move = i[0];
      tick();
    end
    n_tests += 5;
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_halt: got %0b expected 1", halt); end
    if (move_amt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_move_amt: got %0d expected 0", move_amt); end
    if (score !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_score: got %0d expected 0", score); end
    if (game_over !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_game_over: got %0b expected 0", game_over); end
    if (speed_change !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_speed: got %0d expected 0", speed_change); end
    btn_move = 1'b0;
    sys_rst  = 1'b1;
    model_reset();
    ticks(3);
    btn_move = 1'b1;
    ticks(6);
    n_tests++;
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL start_early: halt got %0b expected 1", halt); end
    tick();
    n_tests += 2;
    if (halt !== 1'b0) begin n_fail++; $display("[TB] FAIL start_halt: got %0b expected 0", halt); end
    if (move_amt !== 8'd8) begin n_fail++; $display("[TB] FAIL start_move_amt: got %0d expected 8", move_amt); end
  endtask

  task automatic test_debounce();
    btn_move = 1'b0;
    ticks(6);
    n_tests++;
    if (halt !== 1'b0) begin n_fail++; $display("[TB] FAIL release_early: halt got %0b expected 0", halt); end
    tick();
    n_tests += 2;
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL release_stop: halt got %0b expected 1", halt); end
    if (move_amt !== 8'd0) begin n_fail++; $display("[TB] FAIL release_move_amt: got %0d expected 0", move_amt); end
    for (int i = 0; i < 8; i++) begin
      btn_move = ((i / 2) % 2 == 0);
      tick();
      n_tests++;
      if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL bounce_%0d: halt got %0b expected 1", i, halt); end
    end
    btn_move = 1'b1;
    ticks(6);
    n_tests++;
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL stable_early: halt got %0b expected 1", halt); end
    tick();
    n_tests++;
    if (halt !== 1'b0) begin n_fail++; $display("[TB] FAIL stable_move: halt got %0b expected 0", halt); end
    m_moving = 1'b1;
  endtask

  task automatic test_scoring();
    exp_t e;
    for (int i = 0; i < 25; i++) begin
      drive_pos(pos_in + 11'd8);
      tick();
      e = sb_q.pop_front();
      n_tests++;
      if (score !== e.score) begin n_fail++; $display("[TB] FAIL move_score_%0d: got %0d expected %0d", i, score, e.score); end
    end
    n_tests++;
    if (score !== 16'd5) begin n_fail++; $display("[TB] FAIL move_score_total: got %0d expected 5", score); end
    btn_move = 1'b0;
    ticks(7);
    m_moving = 1'b0;
    n_tests++;
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL enter_stop: halt got %0b expected 1", halt); end
    for (int i = 0; i < 11; i++) begin
      drive_pos((i == 10) ? 11'd2040 : pos_in + 11'd8);
      tick();
      e = sb_q.pop_front();
      n_tests++;
      if (score !== e.score) begin n_fail++; $display("[TB] FAIL stop_score_%0d: got %0d expected %0d", i, score, e.score); end
    end
    btn_move = 1'b1;
    ticks(7);
    m_moving = 1'b1;
    n_tests++;
    if (halt !== 1'b0) begin n_fail++; $display("[TB] FAIL resume_move: halt got %0b expected 0", halt); end
  endtask

  task automatic test_wrap_difficulty();
    exp_t e;
    drive_pos(11'd8);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (score !== e.score) begin n_fail++; $display("[TB] FAIL wrap_score: got %0d expected %0d", score, e.score); end
    drive_pos(11'd32);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (score !== e.score) begin n_fail++; $display("[TB] FAIL wrap_lane: got %0d expected %0d", score, e.score); end
    for (int i = 0; i < 40; i++) begin
      drive_pos(pos_in + 11'd40);
      tick();
      e = sb_q.pop_front();
      n_tests += 2;
      if (score !== e.score) begin n_fail++; $display("[TB] FAIL lane_score_%0d: got %0d expected %0d", i, score, e.score); end
      if (speed_change !== e.speed) begin n_fail++; $display("[TB] FAIL lane_speed_%0d: got %0d expected %0d", i, speed_change, e.speed); end
    end
    n_tests += 2;
    if (score !== 16'd46) begin n_fail++; $display("[TB] FAIL lanes_total: got %0d expected 46", score); end
    if (speed_change !== 8'd12) begin n_fail++; $display("[TB] FAIL speed_saturate: got %0d expected 12", speed_change); end
  endtask

  task automatic test_collision();
    exp_t e;
    collision = 1'b1;
    tick();
    collision = 1'b0;
    n_tests += 3;
    if (game_over !== 1'b1) begin n_fail++; $display("[TB] FAIL dead_game_over: got %0b expected 1", game_over); end
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL dead_halt: got %0b expected 1", halt); end
    if (move_amt !== 8'd0) begin n_fail++; $display("[TB] FAIL dead_move_amt: got %0d expected 0", move_amt); end
    btn_move = 1'b0;
    ticks(7);
    btn_move = 1'b1;
    ticks(7);
    n_tests += 2;
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL dead_btn_halt: got %0b expected 1", halt); end
    if (game_over !== 1'b1) begin n_fail++; $display("[TB] FAIL dead_btn_game_over: got %0b expected 1", game_over); end
    game_rst = 1'b1;
    tick();
    game_rst = 1'b0;
    model_reset();
    n_tests += 4;
    if (game_over !== 1'b0) begin n_fail++; $display("[TB] FAIL grst_game_over: got %0b expected 0", game_over); end
    if (score !== 16'd0) begin n_fail++; $display("[TB] FAIL grst_score: got %0d expected 0", score); end
    if (speed_change !== 8'd0) begin n_fail++; $display("[TB] FAIL grst_speed: got %0d expected 0", speed_change); end
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL grst_halt: got %0b expected 1", halt); end
    collision = 1'b1;
    ticks(3);
    collision = 1'b0;
    n_tests += 2;
    if (game_over !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_collision: game_over got %0b expected 0", game_over); end
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_halt: got %0b expected 1", halt); end
    btn_move = 1'b0;
    ticks(7);
    btn_move = 1'b1;
    ticks(7);
    m_moving = 1'b1;
    n_tests++;
    if (halt !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_move: halt got %0b expected 0", halt); end
    for (int i = 0; i < 2; i++) begin
      drive_pos(pos_in + 11'd40);
      tick();
      e = sb_q.pop_front();
      n_tests++;
      if (score !== e.score) begin n_fail++; $display("[TB] FAIL restart_score_%0d: got %0d expected %0d", i, score, e.score); end
    end
    collision = 1'b1;
    game_rst  = 1'b1;
    tick();
    collision = 1'b0;
    game_rst  = 1'b0;
    model_reset();
    n_tests += 3;
    if (game_over !== 1'b0) begin n_fail++; $display("[TB] FAIL both_game_over: got %0b expected 0", game_over); end
    if (score !== 16'd0) begin n_fail++; $display("[TB] FAIL both_score: got %0d expected 0", score); end
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL both_halt: got %0b expected 1", halt); end
    tick();
    n_tests++;
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL both_idle_hold: halt got %0b expected 1", halt); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    btn_move = 1'b0;
    ticks(7);
    btn_move = 1'b1;
    ticks(7);
    m_moving = 1'b1;
    n_tests++;
    if (halt !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_move: halt got %0b expected 0", halt); end
    for (int i = 0; i < 10; i++) begin
      drive_pos(pos_in + 11'd40);
      tick();
      e = sb_q.pop_front();
      n_tests += 2;
      if (score !== e.score) begin n_fail++; $display("[TB] FAIL arst_score_%0d: got %0d expected %0d", i, score, e.score); end
      if (speed_change !== e.speed) begin n_fail++; $display("[TB] FAIL arst_speed_%0d: got %0d expected %0d", i, speed_change, e.speed); end
    end
    n_tests++;
    if (speed_change !== 8'd4) begin n_fail++; $display("[TB] FAIL arst_first_step: got %0d expected 4", speed_change); end
    #2;
    sys_rst = 1'b0;
    #1;
    n_tests += 3;
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL arst_halt_now: got %0b expected 1", halt); end
    if (score !== 16'd0) begin n_fail++; $display("[TB] FAIL arst_score_now: got %0d expected 0", score); end
    if (speed_change !== 8'd0) begin n_fail++; $display("[TB] FAIL arst_speed_now: got %0d expected 0", speed_change); end
    tick();
    sys_rst = 1'b1;
    model_reset();
    ticks(2);
    n_tests += 4;
    if (speed_change !== 8'd0) begin n_fail++; $display("[TB] FAIL arst_speed_after: got %0d expected 0", speed_change); end
    if (score !== 16'd0) begin n_fail++; $display("[TB] FAIL arst_score_after: got %0d expected 0", score); end
    if (game_over !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_game_over_after: got %0b expected 0", game_over); end
    if (halt !== 1'b1) begin n_fail++; $display("[TB] FAIL arst_halt_after: got %0b expected 1", halt); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_scoring();
    test_wrap_difficulty();
    test_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
